uart_rx_word: RTL and testbench

//  Receive side of the board debug UART link: deserialises 8N1 bytes from rx_pin_in.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/uart_rx_word.sv | 122 ++++++++++++
 tb/tb_uart_rx_word.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Types, widths and helpers shared by the debug UART receive and
//   transmit paths.
//   rx_state_t    : bit-level receiver states
//   clks_per_bit  : integer clocks per bit period for a clock/baud pair
//   BIT_CNT_W     : width of the data-bit index and of the word byte count
//   DIV_W         : width of the bit-period divider (up to 65535 clocks/bit)
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int unsigned BIT_CNT_W = 3;
   localparam int unsigned DIV_W     = 16;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 byte receiver: 2-flop synchroniser, bit-period divider and bit FSM.
//   Ports:
//     clk_i       system clock
//     rst_ni      asynchronous active-low reset
//     rx_i        raw serial line, idle high, asynchronous to clk_i
//     byte_o      received data bits (valid while byte_ok_o is high)
//     byte_ok_o   1-cycle: stop bit sampled high in this cycle
//     byte_err_o  1-cycle: stop bit sampled low in this cycle
//     idle_o      receiver is waiting for a start bit
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_ok_o,
   output logic       byte_err_o,
   output logic       idle_o
);

   // Divider counts down to zero; a reload of N-1 expires N clocks later.
   localparam logic [DIV_W-1:0] FULL_RELOAD = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [DIV_W-1:0] HALF_RELOAD = DIV_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t            state_q;
   logic                 sync_q;
   logic                 rxs_q;
   logic [DIV_W-1:0]     div_q;
   logic [BIT_CNT_W-1:0] bit_q;
   logic [7:0]           shreg_q;
   logic                 expired;

   assign expired = (div_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 1'b1;
         rxs_q   <= 1'b1;
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         sync_q <= rx_i;
         rxs_q  <= sync_q;
         unique case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q <= START;
                  div_q   <= HALF_RELOAD;
               end
            end
            START: begin
               if (expired) begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     div_q   <= FULL_RELOAD;
                     bit_q   <= '0;
                  end
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            DATA: begin
               if (expired) begin
                  shreg_q <= {rxs_q, shreg_q[7:1]};
                  div_q   <= FULL_RELOAD;
                  if (bit_q == BIT_CNT_W'(7)) begin
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            STOP: begin
               if (expired) begin
                  state_q <= rxs_q ? IDLE : BREAK;
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            BREAK: begin
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes are decoded at the stop-sample edge so the word assembler
   // can register its outputs on that same edge.
   assign byte_o     = shreg_q;
   assign byte_ok_o  = (state_q == STOP) && expired && rxs_q;
   assign byte_err_o = (state_q == STOP) && expired && !rxs_q;
   assign idle_o     = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word
//   Debug UART receive path: 8N1 bytes from rx_pin_in are packed into
//   BYTES-byte words for the host-to-memory load path.
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     rx_pin_in    serial line, idle high, asynchronous
//     rx_data      last good byte
//     rx_valid     1-cycle strobe: rx_data updated
//     mdata        last complete word, first byte received in [7:0]
//     mdata_valid  1-cycle strobe: mdata updated (coincides with rx_valid)
//     frame_err    1-cycle strobe: stop bit sampled low
//     byte_cnt     bytes held in the partial word
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned BYTES        = 8,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_pin_in,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic [8*BYTES-1:0]   mdata,
   output logic                 mdata_valid,
   output logic                 frame_err,
   output logic [2:0]           byte_cnt
);

   localparam int unsigned CPB       = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CPB;
   localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

   logic [7:0]           rx_byte;
   logic                 byte_ok;
   logic                 byte_err;
   logic                 idle;

   logic [7:0]           rx_data_q;
   logic                 rx_valid_q;
   logic [8*BYTES-1:0]   mdata_q;
   logic                 mdata_valid_q;
   logic                 frame_err_q;
   logic [BIT_CNT_W-1:0] byte_cnt_q;
   logic [8*BYTES-1:0]   word_q;
   logic [8*BYTES-1:0]   word_d;
   logic [GAP_W-1:0]     gap_q;
   logic                 last_byte;
   logic                 timeout;

   uart_rx_byte #(
      .CLKS_PER_BIT(CPB)
   ) u_rx_byte (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rx_i       (rx_pin_in),
      .byte_o     (rx_byte),
      .byte_ok_o  (byte_ok),
      .byte_err_o (byte_err),
      .idle_o     (idle)
   );

   assign last_byte = (byte_cnt_q == BIT_CNT_W'(BYTES - 1));
   // Gap counter saturates, so a stale partial word is dropped exactly once.
   assign timeout   = idle && (gap_q == GAP_W'(GAP_LIMIT)) && (byte_cnt_q != '0);

   always_comb begin
      word_d = word_q;
      word_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         mdata_q       <= '0;
         mdata_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         byte_cnt_q    <= '0;
         word_q        <= '0;
         gap_q         <= '0;
      end else begin
         rx_valid_q    <= 1'b0;
         mdata_valid_q <= 1'b0;
         frame_err_q   <= byte_err;

         if (byte_ok) begin
            rx_data_q  <= rx_byte;
            rx_valid_q <= 1'b1;
            if (last_byte) begin
               mdata_q       <= word_d;
               mdata_valid_q <= 1'b1;
               word_q        <= '0;
               byte_cnt_q    <= '0;
            end else begin
               word_q     <= word_d;
               byte_cnt_q <= byte_cnt_q + 1'b1;
            end
         end else if (timeout) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
         end

         if (!idle) begin
            gap_q <= '0;
         end else if (gap_q != GAP_W'(GAP_LIMIT)) begin
            gap_q <= gap_q + 1'b1;
         end
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign mdata       = mdata_q;
   assign mdata_valid = mdata_valid_q;
   assign frame_err   = frame_err_q;
   assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word
//   Directed bench for uart_rx_word. A byte-list model predicts strobes,
//   words and byte counts; a negedge compare process checks every strobe.
module tb_uart_rx_word;

   localparam int unsigned CLK_FREQ     = 1_600_000;
   localparam int unsigned BAUD         = 100_000;
   localparam int unsigned BYTES        = 8;
   localparam int unsigned TIMEOUT_BITS = 32;
   localparam int unsigned CPB          = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_pin = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [63:0] mdata;
   logic        mdata_valid;
   logic        frame_err;
   logic [2:0]  byte_cnt;

   always #5 clk = ~clk;

   uart_rx_word #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD         (BAUD),
      .BYTES        (BYTES),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_pin_in   (rx_pin),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .mdata       (mdata),
      .mdata_valid (mdata_valid),
      .frame_err   (frame_err),
      .byte_cnt    (byte_cnt)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;
   int unsigned t_rx = 0;
   int unsigned err_exp = 0;
   int unsigned err_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] cnt;
      logic       last;
   } rx_ev_t;

   rx_ev_t      rx_q[$];
   logic [63:0] word_q[$];
   logic [7:0]  part[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a good byte joins the partial list; a full list becomes a word.
   task automatic model_good(input logic [7:0] d);
      rx_ev_t      e;
      logic [63:0] w;
      part.push_back(d);
      e.d    = d;
      e.last = (part.size() == BYTES);
      if (e.last) begin
         w = '0;
         foreach (part[i]) w = w | (64'(part[i]) << (8 * i));
         word_q.push_back(w);
         part.delete();
      end
      e.cnt = 3'(part.size());
      rx_q.push_back(e);
   endtask

   always @(negedge clk) begin
      rx_ev_t e;
      if (rst_n) begin
         if (rx_valid) begin
            t_rx = cyc;
            if (rx_q.size() == 0) begin
               chk("rx_unexpected", rx_valid, 1'b0);
            end else begin
               e = rx_q.pop_front();
               chk("rx_data", rx_data, e.d);
               chk("byte_cnt_after_rx", byte_cnt, e.cnt);
               chk("mdata_valid_with_rx", mdata_valid, e.last);
               if (e.last && mdata_valid && word_q.size() != 0)
                  chk("mdata", mdata, word_q.pop_front());
            end
         end
         if (mdata_valid && !rx_valid) chk("mdata_without_rx", rx_valid, 1'b1);
         if (frame_err) begin
            err_seen++;
            chk("frame_err_with_rx", rx_valid, 1'b0);
         end
      end
   end

   task automatic drive(input logic v, input int unsigned n);
      rx_pin = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d);
      model_good(d);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(d[i], CPB);
      drive(1'b1, CPB);
   endtask

   task automatic send_bad(input logic [7:0] d);
      err_exp++;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(d[i], CPB);
      drive(1'b0, 2 * CPB);
      drive(1'b1, CPB);
   endtask

   task automatic idle_bits(input int unsigned n);
      drive(1'b1, n * CPB);
      if (n >= TIMEOUT_BITS) part.delete();
   endtask

   task automatic checkpoint(input string tag);
      chk({tag, "_rx_pending"}, 64'(rx_q.size()), 64'd0);
      chk({tag, "_words_pending"}, 64'(word_q.size()), 64'd0);
      chk({tag, "_frame_errs"}, 64'(err_seen), 64'(err_exp));
      chk({tag, "_byte_cnt"}, byte_cnt, 64'(part.size()));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_mdata"}, mdata, 0);
      chk({tag, "_mdata_valid"}, mdata_valid, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_byte_cnt"}, byte_cnt, 0);
   endtask

   initial begin
      int unsigned t0;
      int unsigned lat;
      logic [7:0]  b;

      rst_n  = 1'b0;
      rx_pin = 1'b1;
      repeat (4) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      drive(1'b1, CPB);

      // 1: single byte, latency and counts
      t0 = cyc;
      send_byte(8'hA5);
      drive(1'b1, CPB);
      lat = t_rx - t0;
      chk("t1_rx_data", rx_data, 8'hA5);
      chk("t1_byte_cnt", byte_cnt, 1);
      chk("t1_latency_in_window", (lat >= 154 && lat <= 156), 1'b1);
      checkpoint("t1");
      idle_bits(40);
      checkpoint("t1_timeout");

      // 2: eight back-to-back bytes form one word
      for (int i = 0; i < 8; i++) send_byte(8'(32'h01 + 32'h22 * i));
      drive(1'b1, CPB);
      chk("t2_mdata", mdata, 64'hEFCDAB8967452301);
      chk("t2_byte_cnt", byte_cnt, 0);
      checkpoint("t2");

      // 3: short low glitch is a false start
      send_byte(8'h11);
      send_byte(8'h22);
      drive(1'b1, CPB);
      drive(1'b0, 5);
      drive(1'b1, 3 * CPB);
      chk("t3_byte_cnt", byte_cnt, 2);
      checkpoint("t3");

      // 4: framing error, then a good byte
      send_bad(8'h3C);
      drive(1'b1, CPB);
      send_byte(8'h3C);
      drive(1'b1, CPB);
      chk("t4_rx_data", rx_data, 8'h3C);
      chk("t4_err_count", err_seen, 1);
      chk("t4_byte_cnt", byte_cnt, 3);
      checkpoint("t4");

      // 5: partial word dropped by idle timeout
      idle_bits(40);
      checkpoint("t5_pre");
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      drive(1'b1, CPB);
      chk("t5_byte_cnt_3", byte_cnt, 3);
      idle_bits(40);
      chk("t5_byte_cnt_0", byte_cnt, 0);
      for (int i = 0; i < 8; i++) send_byte(8'(32'h10 + 32'h11 * i));
      drive(1'b1, CPB);
      chk("t5_mdata", mdata, 64'h8776655443322110);
      checkpoint("t5");

      // 6: reset in the middle of the fifth byte's data bits
      idle_bits(2);
      for (int i = 0; i < 4; i++) send_byte(8'(32'hF0 - 32'h0F * i));
      chk("t6_byte_cnt_pre", byte_cnt, 4);
      b = 8'hB4;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t6_reset");
      rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      part.delete();
      rst_n = 1'b1;
      drive(1'b1, 2 * CPB);
      for (int i = 0; i < 8; i++) send_byte(8'(32'hF0 - 32'h0F * i));
      drive(1'b1, CPB);
      chk("t6_mdata", mdata, 64'h8796A5B4C3D2E1F0);
      checkpoint("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
